// File: rtl/pio_out_pulse.sv
// Avalon-MM output PIO driving out_port from a data register, with atomic
// set/clear and a one-shot pulse engine that raises a maskable completion irq.
module pio_out_pulse #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] out_port
);

  typedef enum logic [2:0] {
    A_DATA       = 3'd0,
    A_PULSE_LEN  = 3'd1,
    A_PULSE_TRIG = 3'd2,
    A_STATUS     = 3'd3,
    A_OUTSET     = 3'd4,
    A_OUTCLEAR   = 3'd5,
    A_IRQ_EN     = 3'd6,
    A_RSVD       = 3'd7
  } reg_addr_t;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] data_reg;
  logic [CNT_W-1:0] pulse_len;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pulse_active;
  logic             done;
  logic             irq_en;

  reg_addr_t        addr;
  state_t           state;
  logic             wr;
  logic [WIDTH-1:0] trig_mask;
  logic             trig_accept;
  logic             busy;

  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] active_next;
  logic             done_set;
  logic [31:0]      rd_mux;

  // Upper writedata bits are only meaningful for some registers.
  logic             unused_wdata;
  assign unused_wdata = ^writedata;

  assign addr        = reg_addr_t'(address);
  assign wr          = chipselect && !write_n;
  assign trig_mask   = writedata[WIDTH-1:0];
  assign trig_accept = wr && (addr == A_PULSE_TRIG) && (|trig_mask) && (|pulse_len);
  assign busy        = |pulse_active;
  assign state       = (cnt != '0) ? ACTIVE : IDLE;

  assign out_port = data_reg | pulse_active;
  assign irq      = done & irq_en;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    cnt_next    = cnt;
    active_next = pulse_active;
    done_set    = 1'b0;
    case (state)
      IDLE: begin
        if (trig_accept) begin
          active_next = pulse_active | trig_mask;
          cnt_next    = pulse_len;
        end
      end
      ACTIVE: begin
        // A retrigger reloads the count, so completion fires once for all bits.
        if (trig_accept) begin
          active_next = pulse_active | trig_mask;
          cnt_next    = pulse_len;
        end else if (cnt == CNT_ONE) begin
          active_next = '0;
          cnt_next    = '0;
          done_set    = 1'b1;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_DATA:       rd_mux[WIDTH-1:0] = data_reg;
      A_PULSE_LEN:  rd_mux[CNT_W-1:0] = pulse_len;
      A_PULSE_TRIG: rd_mux[WIDTH-1:0] = pulse_active;
      A_STATUS:     rd_mux[1:0]       = {done, busy};
      A_IRQ_EN:     rd_mux[0]         = irq_en;
      default:      ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg     <= '0;
      pulse_len    <= '0;
      cnt          <= '0;
      pulse_active <= '0;
      done         <= 1'b0;
      irq_en       <= 1'b0;
      readdata     <= '0;
    end else begin
      cnt          <= cnt_next;
      pulse_active <= active_next;
      readdata     <= rd_mux;

      // Completion beats a simultaneous clear-done write.
      if (done_set) begin
        done <= 1'b1;
      end else if (wr && (addr == A_STATUS) && writedata[1]) begin
        done <= 1'b0;
      end

      if (wr) begin
        case (addr)
          A_DATA:      data_reg  <= writedata[WIDTH-1:0];
          A_PULSE_LEN: pulse_len <= writedata[CNT_W-1:0];
          A_OUTSET:    data_reg  <= data_reg | writedata[WIDTH-1:0];
          A_OUTCLEAR:  data_reg  <= data_reg & ~writedata[WIDTH-1:0];
          A_IRQ_EN:    irq_en    <= writedata[0];
          default:     ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pio_out_pulse.sv
// Self-checking bench for pio_out_pulse: directed scenarios plus random
// register traffic checked against a deadline-based behavioural model.
module tb_pio_out_pulse;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [9:0]  out_port;

  int n_cmp = 0;
  int n_fail = 0;

  pio_out_pulse #(.WIDTH(10), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // Reference model: a pulse is a mask plus an absolute end-time in edges.
  longint      now = 0;
  longint      m_end = 0;
  logic [9:0]  m_data = '0;
  logic [15:0] m_len = '0;
  logic [9:0]  m_mask = '0;
  logic        m_done = 1'b0;
  logic        m_irq_en = 1'b0;
  logic [31:0] exp_rd = '0;
  logic [9:0]  exp_out;
  logic        exp_irq;

  assign exp_out = m_data | m_mask;
  assign exp_irq = m_done & m_irq_en;

  task automatic model_edge(input bit rst, input bit wr, input logic [2:0] a, input logic [31:0] d);
    bit expire, accepted;
    now++;
    if (rst) begin
      m_data = '0; m_len = '0; m_mask = '0; m_done = 1'b0; m_irq_en = 1'b0; exp_rd = '0;
      return;
    end
    case (a)
      3'd0: exp_rd = 32'(m_data);
      3'd1: exp_rd = 32'(m_len);
      3'd2: exp_rd = 32'(m_mask);
      3'd3: exp_rd = {30'b0, m_done, (m_mask != 0)};
      3'd6: exp_rd = {31'b0, m_irq_en};
      default: exp_rd = '0;
    endcase
    expire   = (m_mask != 0) && (now == m_end);
    accepted = wr && (a == 3'd2) && (d[9:0] != 0) && (m_len != 0);
    if (wr && a == 3'd3 && d[1]) m_done = 1'b0;
    if (accepted) begin
      m_mask = m_mask | d[9:0];
      m_end  = now + longint'(m_len);
    end else if (expire) begin
      m_mask = '0;
      m_done = 1'b1;
    end
    if (wr) begin
      case (a)
        3'd0: m_data = d[9:0];
        3'd1: m_len = d[15:0];
        3'd4: m_data = m_data | d[9:0];
        3'd5: m_data = m_data & ~d[9:0];
        3'd6: m_irq_en = d[0];
        default: ;
      endcase
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle.
  task automatic step(input bit wr, input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    write_n    = !wr;
    chipselect = wr ? 1'b1 : 1'($urandom_range(0, 1));
    @(posedge clk);
    model_edge(reset, wr, a, d);
    #1;
    write_n    = 1'b1;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(0, 3'd0, 0);
    step(0, 3'd0, 0);
    n_cmp++; if (out_port !== 10'h000) begin n_fail++; $display("FAIL reset_out got=%h exp=000", out_port); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      step(0, 3'(a), 0);
      n_cmp++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_read[%0d] got=%h exp=0", a, readdata); end
    end
  endtask

  task automatic test_data_ops();
    step(1, 3'd0, 32'h2A5);
    step(1, 3'd4, 32'h00A);
    step(1, 3'd5, 32'h201);
    step(0, 3'd0, 0);
    n_cmp++; if (readdata !== 32'h0AE) begin n_fail++; $display("FAIL data_read got=%h exp=0ae", readdata); end
    n_cmp++; if (out_port !== 10'h0AE) begin n_fail++; $display("FAIL data_out got=%h exp=0ae", out_port); end
  endtask

  task automatic test_pulse();
    step(1, 3'd0, 32'h0);
    step(1, 3'd1, 32'd5);
    step(1, 3'd6, 32'h1);
    step(1, 3'd2, 32'h003);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_port !== 10'h003) begin n_fail++; $display("FAIL pulse_high[%0d] got=%h exp=003", i, out_port); end
      n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL pulse_irq_early[%0d] got=%b exp=0", i, irq); end
      step(0, 3'd3, 0);
    end
    n_cmp++; if (out_port !== 10'h000) begin n_fail++; $display("FAIL pulse_end got=%h exp=000", out_port); end
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pulse_irq got=%b exp=1", irq); end
    step(0, 3'd3, 0);
    n_cmp++; if (readdata !== 32'h2) begin n_fail++; $display("FAIL pulse_status got=%h exp=2", readdata); end
    step(1, 3'd3, 32'h2);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL pulse_irq_clear got=%b exp=0", irq); end
  endtask

  task automatic test_len_one();
    step(1, 3'd1, 32'd1);
    step(1, 3'd2, 32'h200);
    n_cmp++; if (out_port !== 10'h200) begin n_fail++; $display("FAIL len1_high got=%h exp=200", out_port); end
    step(0, 3'd3, 0);
    n_cmp++; if (out_port !== 10'h000 || irq !== 1'b1) begin
      n_fail++; $display("FAIL len1_end got out=%h irq=%b exp out=000 irq=1", out_port, irq);
    end
    step(1, 3'd3, 32'h2);
  endtask

  task automatic test_back_to_back();
    int rises = 0;
    logic prev;
    step(1, 3'd1, 32'd4);
    step(1, 3'd2, 32'h001);
    step(0, 3'd2, 0);
    n_cmp++; if (out_port !== 10'h001) begin n_fail++; $display("FAIL retrig_first got=%h exp=001", out_port); end
    step(1, 3'd2, 32'h100);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_port !== 10'h101) begin n_fail++; $display("FAIL retrig_high[%0d] got=%h exp=101", i, out_port); end
      prev = irq;
      step(0, 3'd3, 0);
      if (irq && !prev) rises++;
    end
    n_cmp++; if (out_port !== 10'h000) begin n_fail++; $display("FAIL retrig_end got=%h exp=000", out_port); end
    for (int i = 0; i < 3; i++) begin
      prev = irq;
      step(0, 3'd3, 0);
      if (irq && !prev) rises++;
    end
    n_cmp++; if (rises !== 1) begin n_fail++; $display("FAIL retrig_done_count got=%0d exp=1", rises); end
    step(1, 3'd3, 32'h2);
  endtask

  task automatic test_ignored_trigger();
    step(1, 3'd0, 32'h0F0);
    step(1, 3'd1, 32'd0);
    step(1, 3'd2, 32'h3FF);
    step(0, 3'd3, 0);
    n_cmp++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL ign_len0_status got=%h exp=0", readdata); end
    n_cmp++; if (out_port !== 10'h0F0) begin n_fail++; $display("FAIL ign_len0_out got=%h exp=0f0", out_port); end
    step(1, 3'd1, 32'd3);
    step(1, 3'd2, 32'h0);
    step(0, 3'd3, 0);
    n_cmp++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL ign_mask0_status got=%h exp=0", readdata); end
    n_cmp++; if (out_port !== 10'h0F0) begin n_fail++; $display("FAIL ign_mask0_out got=%h exp=0f0", out_port); end
  endtask

  task automatic test_reset_mid_pulse();
    step(1, 3'd0, 32'h055);
    step(1, 3'd6, 32'h1);
    step(1, 3'd1, 32'd10);
    step(1, 3'd2, 32'h003);
    step(0, 3'd0, 0);
    n_cmp++; if (out_port !== 10'h057) begin n_fail++; $display("FAIL rstmid_pre got=%h exp=057", out_port); end
    reset = 1'b1;
    step(0, 3'd3, 0);
    reset = 1'b0;
    n_cmp++; if (out_port !== 10'h000 || irq !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_out got out=%h irq=%b exp out=000 irq=0", out_port, irq);
    end
    for (int a = 0; a < 8; a++) begin
      step(0, 3'(a), 0);
      n_cmp++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_read[%0d] got=%h exp=0", a, readdata); end
    end
    for (int i = 0; i < 12; i++) step(0, 3'd3, 0);
    n_cmp++; if (readdata !== 32'h0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_done got status=%h irq=%b exp 0/0", readdata, irq);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, d;
    logic [2:0]  a;
    bit          wr;
    for (int i = 0; i < 1500; i++) begin
      r  = $urandom;
      a  = 3'($urandom_range(0, 7));
      wr = ($urandom_range(0, 2) != 0);
      d  = r;
      if (a == 3'd1) d = {r[31:16], 16'($urandom_range(0, 9))};
      if (a == 3'd2 && $urandom_range(0, 5) == 0) d = {r[31:10], 10'h0};
      reset = ($urandom_range(0, 199) == 0);
      step(wr, a, d);
      reset = 1'b0;
      n_cmp++; if (out_port !== exp_out) begin n_fail++; $display("FAIL rnd_out[%0d] got=%h exp=%h", i, out_port, exp_out); end
      n_cmp++; if (irq !== exp_irq) begin n_fail++; $display("FAIL rnd_irq[%0d] got=%b exp=%b", i, irq, exp_irq); end
      n_cmp++; if (readdata !== exp_rd) begin n_fail++; $display("FAIL rnd_read[%0d] got=%h exp=%h", i, readdata, exp_rd); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_data_ops();
    test_pulse();
    test_len_one();
    test_back_to_back();
    test_ignored_trigger();
    test_reset_mid_pulse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
